fetch_pc_generator: RTL and testbench

Front-end PC sequencer that drives the search side of `branch_predictor` and consumes its registered prediction one cycle later. It issues sequential fetch addresses and redirects to the predicted target on a predicted-taken branch, with a one-cycle bubble. It also handles pipeline flush/redirect and downstream stall. Each issued address is presented to the fetch stage together with its prediction.

---
 rtl/fetch_pc_generator.sv | 108 ++++++++++
 tb/tb_fetch_pc_generator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_generator.sv
// Front-end fetch PC sequencer: drives the branch predictor search port and
// attaches the registered prediction to each issued fetch address one cycle later.
module fetch_pc_generator #(
   parameter logic [31:0]    RESET_VECTOR = 32'h0000_0000,
   localparam int unsigned   ADDR_W       = 32
) (
   input  logic              iCLOCK,
   input  logic              inRESET,
   input  logic              iSTART,
   input  logic              iFLUSH,
   input  logic [ADDR_W-1:0] iFLUSH_ADDR,
   input  logic              iNEXT_LOCK,
   output logic              oPREDICT_FLUSH,
   output logic              oPREDICT_SEARCH_STB,
   output logic [ADDR_W-1:0] oPREDICT_SEARCH_INST_ADDR,
   output logic              oPREDICT_SEARCH_LOCK,
   input  logic              iPREDICT_SEARCH_VALID,
   input  logic              iPREDICT_BRANCH,
   input  logic [ADDR_W-1:0] iPREDICT_ADDR,
   output logic              oINST_VALID,
   output logic [ADDR_W-1:0] oINST_ADDR,
   output logic              oINST_PREDICT_BRANCH,
   output logic [ADDR_W-1:0] oINST_PREDICT_ADDR
);

   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_d;
   logic              s1_valid;
   logic              s1_valid_d;
   logic [ADDR_W-1:0] s1_addr;
   logic [ADDR_W-1:0] s1_addr_d;

   logic              pv;
   logic              taken;
   logic              issue;
   logic [ADDR_W-1:0] flush_pc;
   logic [ADDR_W-1:0] predict_pc;

   // Prediction applies only to the address currently held in s1.
   assign pv         = s1_valid & iPREDICT_SEARCH_VALID;
   assign taken      = pv & iPREDICT_BRANCH;
   assign issue      = (state_q == RUN) & ~iNEXT_LOCK & ~iFLUSH & ~taken;
   assign flush_pc   = iFLUSH_ADDR & WORD_MASK;
   assign predict_pc = iPREDICT_ADDR & WORD_MASK;

   assign oPREDICT_FLUSH            = iFLUSH;
   assign oPREDICT_SEARCH_STB       = issue;
   assign oPREDICT_SEARCH_INST_ADDR = pc_r;
   assign oPREDICT_SEARCH_LOCK      = (state_q == IDLE) | (iNEXT_LOCK & ~iFLUSH);
   assign oINST_VALID               = s1_valid;
   assign oINST_ADDR                = s1_addr;
   assign oINST_PREDICT_BRANCH      = taken;
   assign oINST_PREDICT_ADDR        = taken ? predict_pc : '0;

   // State and PC register file.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q  <= IDLE;
         pc_r     <= RESET_VECTOR & WORD_MASK;
         s1_valid <= 1'b0;
         s1_addr  <= '0;
      end else begin
         state_q  <= state_d;
         pc_r     <= pc_d;
         s1_valid <= s1_valid_d;
         s1_addr  <= s1_addr_d;
      end
   end

   // Next-state: flush beats idle, idle beats lock, lock beats a taken redirect.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_r;
      s1_valid_d = s1_valid;
      s1_addr_d  = s1_addr;

      if ((state_q == IDLE) && (iSTART || iFLUSH)) begin
         state_d = RUN;
      end

      if (iFLUSH) begin
         pc_d       = flush_pc;
         s1_valid_d = 1'b0;
      end else if (state_q == IDLE) begin
         pc_d = pc_r;
      end else if (iNEXT_LOCK) begin
         pc_d = pc_r;
      end else if (taken) begin
         pc_d       = predict_pc;
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = 1'b1;
         s1_addr_d  = pc_r;
         pc_d       = pc_r + PC_STEP;
      end
   end

endmodule

// File: tb/tb_fetch_pc_generator.sv
// Bench for fetch_pc_generator: directed scenarios plus randomized traffic
// checked against a fetch-stream reference model.
module tb_fetch_pc_generator;

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        iCLOCK = 1'b0;
   logic        inRESET;
   logic        iSTART;
   logic        iFLUSH;
   logic [31:0] iFLUSH_ADDR;
   logic        iNEXT_LOCK;
   logic        oPREDICT_FLUSH;
   logic        oPREDICT_SEARCH_STB;
   logic [31:0] oPREDICT_SEARCH_INST_ADDR;
   logic        oPREDICT_SEARCH_LOCK;
   logic        iPREDICT_SEARCH_VALID;
   logic        iPREDICT_BRANCH;
   logic [31:0] iPREDICT_ADDR;
   logic        oINST_VALID;
   logic [31:0] oINST_ADDR;
   logic        oINST_PREDICT_BRANCH;
   logic [31:0] oINST_PREDICT_ADDR;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: whether fetching is active, the next address to fetch,
   // and the address (if any) currently presented to the fetch stage.
   bit          m_run;
   logic [31:0] m_pc;
   bit          m_has;
   logic [31:0] m_addr;

   always #5 iCLOCK = ~iCLOCK;

   fetch_pc_generator #(.RESET_VECTOR(RV)) dut (
      .iCLOCK                    (iCLOCK),
      .inRESET                   (inRESET),
      .iSTART                    (iSTART),
      .iFLUSH                    (iFLUSH),
      .iFLUSH_ADDR               (iFLUSH_ADDR),
      .iNEXT_LOCK                (iNEXT_LOCK),
      .oPREDICT_FLUSH            (oPREDICT_FLUSH),
      .oPREDICT_SEARCH_STB       (oPREDICT_SEARCH_STB),
      .oPREDICT_SEARCH_INST_ADDR (oPREDICT_SEARCH_INST_ADDR),
      .oPREDICT_SEARCH_LOCK      (oPREDICT_SEARCH_LOCK),
      .iPREDICT_SEARCH_VALID     (iPREDICT_SEARCH_VALID),
      .iPREDICT_BRANCH           (iPREDICT_BRANCH),
      .iPREDICT_ADDR             (iPREDICT_ADDR),
      .oINST_VALID               (oINST_VALID),
      .oINST_ADDR                (oINST_ADDR),
      .oINST_PREDICT_BRANCH      (oINST_PREDICT_BRANCH),
      .oINST_PREDICT_ADDR        (oINST_PREDICT_ADDR)
   );

   function automatic bit m_taken();
      return m_has && (iPREDICT_SEARCH_VALID === 1'b1) && (iPREDICT_BRANCH === 1'b1);
   endfunction

   task automatic m_reset();
      m_run  = 1'b0;
      m_pc   = RV;
      m_has  = 1'b0;
      m_addr = 32'h0;
   endtask

   // Apply one cycle of inputs mid-period; outputs are sampled 1 time unit later.
   task automatic drive(input logic s, input logic f, input logic [31:0] fa,
                        input logic l, input logic v, input logic b, input logic [31:0] pa);
      @(negedge iCLOCK);
      iSTART = s; iFLUSH = f; iFLUSH_ADDR = fa; iNEXT_LOCK = l;
      iPREDICT_SEARCH_VALID = v; iPREDICT_BRANCH = b; iPREDICT_ADDR = pa;
      #1;
   endtask

   // Move the model across the next rising edge using the inputs now applied.
   task automatic advance();
      bit          n_run;
      bit          n_has;
      logic [31:0] n_pc;
      logic [31:0] n_addr;
      n_run  = m_run || iSTART || iFLUSH;
      n_pc   = m_pc;
      n_has  = m_has;
      n_addr = m_addr;
      if (iFLUSH) begin
         n_pc  = {iFLUSH_ADDR[31:2], 2'b00};
         n_has = 1'b0;
      end else if (m_run && !iNEXT_LOCK) begin
         if (m_taken()) begin
            n_pc  = {iPREDICT_ADDR[31:2], 2'b00};
            n_has = 1'b0;
         end else begin
            n_addr = m_pc;
            n_has  = 1'b1;
            n_pc   = m_pc + 32'd4;
         end
      end
      @(posedge iCLOCK);
      m_run = n_run; m_pc = n_pc; m_has = n_has; m_addr = n_addr;
   endtask

   task automatic test_reset();
      inRESET = 1'b0;
      iSTART = 0; iFLUSH = 0; iFLUSH_ADDR = 0; iNEXT_LOCK = 0;
      iPREDICT_SEARCH_VALID = 0; iPREDICT_BRANCH = 0; iPREDICT_ADDR = 0;
      m_reset();
      repeat (2) @(negedge iCLOCK);
      inRESET = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
         n_cmp++; if (oPREDICT_SEARCH_STB !== 1'b0) begin n_bad++; $display("FAIL reset_stb[%0d]: got %b want 0", i, oPREDICT_SEARCH_STB); end
         n_cmp++; if (oINST_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, oINST_VALID); end
         n_cmp++; if (oPREDICT_SEARCH_INST_ADDR !== 32'h100) begin n_bad++; $display("FAIL reset_search_addr[%0d]: got %h want 00000100", i, oPREDICT_SEARCH_INST_ADDR); end
         n_cmp++; if (oPREDICT_SEARCH_LOCK !== 1'b1) begin n_bad++; $display("FAIL reset_lock[%0d]: got %b want 1", i, oPREDICT_SEARCH_LOCK); end
         advance();
      end
   endtask

   task automatic test_sequential();
      drive(1, 0, 32'h0, 0, 1, 0, 32'h0);
      n_cmp++; if (oPREDICT_SEARCH_STB !== 1'b0) begin n_bad++; $display("FAIL seq_idle_stb: got %b want 0", oPREDICT_SEARCH_STB); end
      advance();
      drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
      n_cmp++; if (oPREDICT_SEARCH_STB !== 1'b1) begin n_bad++; $display("FAIL seq_first_stb: got %b want 1", oPREDICT_SEARCH_STB); end
      n_cmp++; if (oPREDICT_SEARCH_INST_ADDR !== 32'h100) begin n_bad++; $display("FAIL seq_first_search: got %h want 00000100", oPREDICT_SEARCH_INST_ADDR); end
      n_cmp++; if (oINST_VALID !== 1'b0) begin n_bad++; $display("FAIL seq_first_valid: got %b want 0", oINST_VALID); end
      advance();
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
         n_cmp++; if (oINST_VALID !== 1'b1 || oINST_ADDR !== 32'h100 + 32'(4 * k)) begin
            n_bad++; $display("FAIL seq_addr[%0d]: got v=%b %h want v=1 %h", k, oINST_VALID, oINST_ADDR, 32'h100 + 32'(4 * k));
         end
         n_cmp++; if (oINST_PREDICT_BRANCH !== 1'b0) begin n_bad++; $display("FAIL seq_not_taken[%0d]: got %b want 0", k, oINST_PREDICT_BRANCH); end
         advance();
      end
   endtask

   task automatic test_taken_branch();
      drive(0, 0, 32'h0, 0, 1, 1, 32'h2002);
      n_cmp++; if (oINST_VALID !== 1'b1 || oINST_ADDR !== 32'h108) begin n_bad++; $display("FAIL taken_addr: got v=%b %h want v=1 00000108", oINST_VALID, oINST_ADDR); end
      n_cmp++; if (oINST_PREDICT_BRANCH !== 1'b1) begin n_bad++; $display("FAIL taken_branch: got %b want 1", oINST_PREDICT_BRANCH); end
      n_cmp++; if (oINST_PREDICT_ADDR !== 32'h2000) begin n_bad++; $display("FAIL taken_target: got %h want 00002000", oINST_PREDICT_ADDR); end
      n_cmp++; if (oPREDICT_SEARCH_STB !== 1'b0) begin n_bad++; $display("FAIL taken_stb: got %b want 0", oPREDICT_SEARCH_STB); end
      advance();
      drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
      n_cmp++; if (oINST_VALID !== 1'b0) begin n_bad++; $display("FAIL taken_bubble: got %b want 0", oINST_VALID); end
      n_cmp++; if (oPREDICT_SEARCH_STB !== 1'b1 || oPREDICT_SEARCH_INST_ADDR !== 32'h2000) begin
         n_bad++; $display("FAIL taken_search: got stb=%b %h want stb=1 00002000", oPREDICT_SEARCH_STB, oPREDICT_SEARCH_INST_ADDR);
      end
      advance();
      drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
      n_cmp++; if (oINST_VALID !== 1'b1 || oINST_ADDR !== 32'h2000) begin n_bad++; $display("FAIL taken_emit: got v=%b %h want v=1 00002000", oINST_VALID, oINST_ADDR); end
      advance();
   endtask

   task automatic test_lock();
      drive(0, 1, 32'h10C, 0, 1, 0, 32'h0);
      advance();
      drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
      n_cmp++; if (oPREDICT_SEARCH_INST_ADDR !== 32'h10C) begin n_bad++; $display("FAIL lock_setup: got %h want 0000010c", oPREDICT_SEARCH_INST_ADDR); end
      advance();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 32'h0, 1, 1, 0, 32'h0);
         n_cmp++; if (oINST_VALID !== 1'b1 || oINST_ADDR !== 32'h10C) begin n_bad++; $display("FAIL lock_hold_addr[%0d]: got v=%b %h want v=1 0000010c", i, oINST_VALID, oINST_ADDR); end
         n_cmp++; if (oPREDICT_SEARCH_STB !== 1'b0) begin n_bad++; $display("FAIL lock_stb[%0d]: got %b want 0", i, oPREDICT_SEARCH_STB); end
         n_cmp++; if (oPREDICT_SEARCH_LOCK !== 1'b1) begin n_bad++; $display("FAIL lock_search_lock[%0d]: got %b want 1", i, oPREDICT_SEARCH_LOCK); end
         advance();
      end
      drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
      n_cmp++; if (oPREDICT_SEARCH_STB !== 1'b1 || oPREDICT_SEARCH_INST_ADDR !== 32'h110) begin
         n_bad++; $display("FAIL lock_release_search: got stb=%b %h want stb=1 00000110", oPREDICT_SEARCH_STB, oPREDICT_SEARCH_INST_ADDR);
      end
      advance();
      drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
      n_cmp++; if (oINST_VALID !== 1'b1 || oINST_ADDR !== 32'h110) begin n_bad++; $display("FAIL lock_resume: got v=%b %h want v=1 00000110", oINST_VALID, oINST_ADDR); end
      advance();
   endtask

   task automatic test_flush_priority();
      drive(0, 1, 32'h4000, 1, 1, 1, 32'h3000);
      n_cmp++; if (oPREDICT_FLUSH !== 1'b1) begin n_bad++; $display("FAIL flush_passthru: got %b want 1", oPREDICT_FLUSH); end
      n_cmp++; if (oPREDICT_SEARCH_STB !== 1'b0) begin n_bad++; $display("FAIL flush_stb: got %b want 0", oPREDICT_SEARCH_STB); end
      n_cmp++; if (oPREDICT_SEARCH_LOCK !== 1'b0) begin n_bad++; $display("FAIL flush_over_lock: got %b want 0", oPREDICT_SEARCH_LOCK); end
      advance();
      drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
      n_cmp++; if (oINST_VALID !== 1'b0) begin n_bad++; $display("FAIL flush_bubble: got %b want 0", oINST_VALID); end
      n_cmp++; if (oPREDICT_SEARCH_INST_ADDR !== 32'h4000) begin n_bad++; $display("FAIL flush_search: got %h want 00004000", oPREDICT_SEARCH_INST_ADDR); end
      advance();
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
         n_cmp++; if (oINST_VALID !== 1'b1 || oINST_ADDR !== 32'h4000 + 32'(4 * k)) begin
            n_bad++; $display("FAIL flush_emit[%0d]: got v=%b %h want v=1 %h", k, oINST_VALID, oINST_ADDR, 32'h4000 + 32'(4 * k));
         end
         advance();
      end
   endtask

   task automatic test_wrap();
      logic [31:0] want [3];
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
      drive(0, 1, 32'hFFFF_FFFB, 0, 1, 0, 32'h0);
      advance();
      drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
      n_cmp++; if (oPREDICT_SEARCH_INST_ADDR !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_align: got %h want fffffff8", oPREDICT_SEARCH_INST_ADDR); end
      advance();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 32'h0, 0, 1, 0, 32'h0);
         n_cmp++; if (oINST_VALID !== 1'b1 || oINST_ADDR !== want[k]) begin
            n_bad++; $display("FAIL wrap_emit[%0d]: got v=%b %h want v=1 %h", k, oINST_VALID, oINST_ADDR, want[k]);
         end
         advance();
      end
   endtask

   task automatic test_async_reset();
      drive(0, 0, 32'h0, 0, 1, 1, 32'h8000);
      n_cmp++; if (oINST_VALID !== 1'b1 || oINST_PREDICT_BRANCH !== 1'b1) begin
         n_bad++; $display("FAIL areset_pre: got v=%b br=%b want v=1 br=1", oINST_VALID, oINST_PREDICT_BRANCH);
      end
      inRESET = 1'b0;
      #1;
      n_cmp++; if (oPREDICT_SEARCH_STB !== 1'b0) begin n_bad++; $display("FAIL areset_stb: got %b want 0", oPREDICT_SEARCH_STB); end
      n_cmp++; if (oPREDICT_SEARCH_LOCK !== 1'b1) begin n_bad++; $display("FAIL areset_lock: got %b want 1", oPREDICT_SEARCH_LOCK); end
      n_cmp++; if (oINST_VALID !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b want 0", oINST_VALID); end
      n_cmp++; if (oINST_PREDICT_BRANCH !== 1'b0) begin n_bad++; $display("FAIL areset_branch: got %b want 0", oINST_PREDICT_BRANCH); end
      n_cmp++; if (oINST_PREDICT_ADDR !== 32'h0) begin n_bad++; $display("FAIL areset_target: got %h want 00000000", oINST_PREDICT_ADDR); end
      n_cmp++; if (oPREDICT_SEARCH_INST_ADDR !== RV) begin n_bad++; $display("FAIL areset_search: got %h want %h", oPREDICT_SEARCH_INST_ADDR, RV); end
      n_cmp++; if (oPREDICT_FLUSH !== 1'b0) begin n_bad++; $display("FAIL areset_flush: got %b want 0", oPREDICT_FLUSH); end
      @(negedge iCLOCK);
      inRESET = 1'b1;
      m_reset();
   endtask

   task automatic test_random();
      logic        e_taken;
      logic        e_stb;
      logic        e_lock;
      logic [31:0] e_target;
      logic [31:0] fa;
      for (int i = 0; i < 3000; i++) begin
         fa = $urandom;
         if ($urandom_range(0, 3) == 0) fa = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0), fa,
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) != 0),
               ($urandom_range(0, 3) == 0), $urandom);
         e_taken  = m_taken();
         e_stb    = m_run && !iNEXT_LOCK && !iFLUSH && !e_taken;
         e_lock   = !m_run || (iNEXT_LOCK && !iFLUSH);
         e_target = e_taken ? {iPREDICT_ADDR[31:2], 2'b00} : 32'h0;
         n_cmp++; if (oPREDICT_FLUSH !== iFLUSH) begin n_bad++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, oPREDICT_FLUSH, iFLUSH); end
         n_cmp++; if (oPREDICT_SEARCH_STB !== e_stb) begin n_bad++; $display("FAIL rnd_stb[%0d]: got %b want %b", i, oPREDICT_SEARCH_STB, e_stb); end
         n_cmp++; if (oPREDICT_SEARCH_INST_ADDR !== m_pc) begin n_bad++; $display("FAIL rnd_search[%0d]: got %h want %h", i, oPREDICT_SEARCH_INST_ADDR, m_pc); end
         n_cmp++; if (oPREDICT_SEARCH_LOCK !== e_lock) begin n_bad++; $display("FAIL rnd_lock[%0d]: got %b want %b", i, oPREDICT_SEARCH_LOCK, e_lock); end
         n_cmp++; if (oINST_VALID !== m_has) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, oINST_VALID, m_has); end
         n_cmp++; if (m_has && oINST_ADDR !== m_addr) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, oINST_ADDR, m_addr); end
         n_cmp++; if (oINST_PREDICT_BRANCH !== e_taken) begin n_bad++; $display("FAIL rnd_branch[%0d]: got %b want %b", i, oINST_PREDICT_BRANCH, e_taken); end
         n_cmp++; if (oINST_PREDICT_ADDR !== e_target) begin n_bad++; $display("FAIL rnd_target[%0d]: got %h want %h", i, oINST_PREDICT_ADDR, e_target); end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_taken_branch();
      test_lock();
      test_flush_priority();
      test_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
